// File: rtl/fpaddsub_pkg.sv
// Shared widths and constants for the FP add/sub datapath stages.
package fpaddsub_pkg;

  localparam int unsigned MANT_W    = 25;
  localparam int unsigned EXP_W     = 8;
  localparam int unsigned SHIFT_SAT = 25;

endpackage

// File: rtl/fpaddsub_align_shifter.sv
// Combinational alignment shifter: right-shifts the smaller mantissa by the
// exponent difference and collects the shifted-out bits into a sticky bit.
module fpaddsub_align_shifter
  import fpaddsub_pkg::*;
#(
  parameter int unsigned MANT_W = fpaddsub_pkg::MANT_W,
  parameter int unsigned EXP_W  = fpaddsub_pkg::EXP_W
) (
  input  logic [MANT_W-1:0] Msmall,
  input  logic [EXP_W-1:0]  diff,
  output logic [MANT_W-1:0] Mal,
  output logic              Sticky
);

  always_comb begin
    Mal    = '0;
    Sticky = 1'b0;
    if (diff > EXP_W'(SHIFT_SAT)) begin
      Sticky = |Msmall;
    end else begin
      Mal    = Msmall >> diff;
      // Mask of the low diff bits; a full-width shift leaves all ones.
      Sticky = |(Msmall & ~({MANT_W{1'b1}} << diff));
    end
  end

endmodule

// File: rtl/fpaddsub_align_stage.sv
// Two-stage alignment pipeline: stage 1 orders operands by magnitude,
// stage 2 aligns the smaller mantissa. Valid/ready with per-stage occupancy.
module fpaddsub_align_stage
  import fpaddsub_pkg::*;
#(
  parameter int unsigned MANT_W = fpaddsub_pkg::MANT_W,
  parameter int unsigned EXP_W  = fpaddsub_pkg::EXP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              Sa,
  input  logic              Sb,
  input  logic [EXP_W-1:0]  Ea,
  input  logic [EXP_W-1:0]  Eb,
  input  logic [MANT_W-1:0] Ma,
  input  logic [MANT_W-1:0] Mb,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              Sl,
  output logic              OpSub,
  output logic              Swap,
  output logic [EXP_W-1:0]  Emax,
  output logic [MANT_W-1:0] Mmax,
  output logic [MANT_W-1:0] Mal,
  output logic              Sticky
);

  logic ld1, ld2;

  logic              v1_q;
  logic              s1_sl_q, s1_sl_d;
  logic              s1_opsub_q, s1_opsub_d;
  logic              s1_swap_q, s1_swap_d;
  logic [EXP_W-1:0]  s1_emax_q, s1_emax_d;
  logic [MANT_W-1:0] s1_mmax_q, s1_mmax_d;
  logic [MANT_W-1:0] s1_msmall_q, s1_msmall_d;
  logic [EXP_W-1:0]  s1_diff_q, s1_diff_d;

  logic              v2_q;
  logic              sl_q, opsub_q, swap_q, sticky_q;
  logic [EXP_W-1:0]  emax_q;
  logic [MANT_W-1:0] mmax_q, mal_q;

  logic [MANT_W-1:0] mal_d;
  logic              sticky_d;

  assign ld2      = ~v2_q | out_ready;
  assign ld1      = ~v1_q | ld2;
  assign in_ready = ld1;

  always_comb begin
    s1_swap_d   = ({Ea, Ma} < {Eb, Mb});
    s1_opsub_d  = Sa ^ Sb;
    s1_sl_d     = Sa;
    s1_emax_d   = Ea;
    s1_mmax_d   = Ma;
    s1_msmall_d = Mb;
    s1_diff_d   = Ea - Eb;
    if (s1_swap_d) begin
      s1_sl_d     = Sb;
      s1_emax_d   = Eb;
      s1_mmax_d   = Mb;
      s1_msmall_d = Ma;
      s1_diff_d   = Eb - Ea;
    end
  end

  fpaddsub_align_shifter #(
    .MANT_W(MANT_W),
    .EXP_W (EXP_W)
  ) u_shifter (
    .Msmall(s1_msmall_q),
    .diff  (s1_diff_q),
    .Mal   (mal_d),
    .Sticky(sticky_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q        <= 1'b0;
      s1_sl_q     <= 1'b0;
      s1_opsub_q  <= 1'b0;
      s1_swap_q   <= 1'b0;
      s1_emax_q   <= '0;
      s1_mmax_q   <= '0;
      s1_msmall_q <= '0;
      s1_diff_q   <= '0;
      v2_q        <= 1'b0;
      sl_q        <= 1'b0;
      opsub_q     <= 1'b0;
      swap_q      <= 1'b0;
      emax_q      <= '0;
      mmax_q      <= '0;
      mal_q       <= '0;
      sticky_q    <= 1'b0;
    end else begin
      if (ld1) begin
        v1_q <= in_valid;
        if (in_valid) begin
          s1_sl_q     <= s1_sl_d;
          s1_opsub_q  <= s1_opsub_d;
          s1_swap_q   <= s1_swap_d;
          s1_emax_q   <= s1_emax_d;
          s1_mmax_q   <= s1_mmax_d;
          s1_msmall_q <= s1_msmall_d;
          s1_diff_q   <= s1_diff_d;
        end
      end
      if (ld2) begin
        v2_q <= v1_q;
        if (v1_q) begin
          sl_q     <= s1_sl_q;
          opsub_q  <= s1_opsub_q;
          swap_q   <= s1_swap_q;
          emax_q   <= s1_emax_q;
          mmax_q   <= s1_mmax_q;
          mal_q    <= mal_d;
          sticky_q <= sticky_d;
        end
      end
    end
  end

  assign out_valid = v2_q;
  assign Sl        = sl_q;
  assign OpSub     = opsub_q;
  assign Swap      = swap_q;
  assign Emax      = emax_q;
  assign Mmax      = mmax_q;
  assign Mal       = mal_q;
  assign Sticky    = sticky_q;

endmodule

// File: doc/fpaddsub_align_stage.md
# fpaddsub_align_stage

Two-stage pipelined alignment stage of the FP adder/subtractor. Consumes the unpacked sign, exponent and 25-bit explicit-one mantissa of A and B produced by the pre-alignment stage. Orders the operands by magnitude and right-shifts the smaller mantissa by the exponent difference with a sticky bit. Feeds the add/normalise stage through a valid/ready handshake.

## Interface
Parameters:
- MANT_W, 25, mantissa width (explicit 1 + 23 fraction + 1 guard)
- EXP_W, 8, exponent width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  upstream operands valid
- in_ready  out  1  stage can accept operands this cycle
- Sa, Sb  in  1 each  operand signs
- Ea, Eb  in  EXP_W each  operand exponents (denormals already forced to 1)
- Ma, Mb  in  MANT_W each  operand mantissas
- out_valid  out  1  aligned result valid
- out_ready  in  1  downstream accepts result
- Sl  out  1  sign of the larger-magnitude operand
- OpSub  out  1  Sa XOR Sb, effective subtraction
- Swap  out  1  B was larger and took the "large" slot
- Emax  out  EXP_W  exponent of the larger operand
- Mmax  out  MANT_W  mantissa of the larger operand, unshifted
- Mal  out  MANT_W  smaller mantissa after the right shift
- Sticky  out  1  OR of all bits shifted out of Mal

## Operation
- Stage 1 (compare/swap):
  - Compare {Ea,Ma} against {Eb,Mb} as an unsigned 33-bit value.
  - A is large when A ≥ B; otherwise Swap=1 and the operands are exchanged.
  - Register large/small sign, exponent and mantissa, OpSub, Swap, and diff = Elarge − Esmall (EXP_W bits, never negative).
- Stage 2 (shift):
  - diff ≤ 25: Mal = Msmall >> diff; Sticky = OR of the low diff bits of Msmall (0 when diff=0).
  - diff > 25: Mal = 0; Sticky = |Msmall.
  - Register all outputs.
- Exponents 255 (Inf/NaN) are not treated specially here; exception flags travel on a separate path.
- Arithmetic is unsigned throughout. No rounding in this stage.

## Timing
- Latency: 2 cycles from an accepted input (in_valid & in_ready) to out_valid.
- Throughput: 1 per cycle while out_ready=1.
- Transfers:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - out_* data is held stable while out_valid & ~out_ready.
- Per-stage occupancy bits v1 and v2:
  - Stage 2 loads when ~v2 | out_ready.
  - Stage 1 loads when ~v1 | stage 2 loads.
  - in_ready = ~v1 | (~v2 | out_ready), combinational from out_ready.
- Simultaneous input accept and output consume with both stages full: all stages advance, no bubble, no loss.
- Backpressure: at most 2 items are held. in_ready falls only when both stages are full and out_ready=0.
- Reset values: v1=v2=0, out_valid=0, in_ready=1 during the cycle after reset. All data outputs are 0.
- rst asserted mid-operation: in-flight items are discarded; state is as above on the next edge.
- Data registers are also cleared by rst for deterministic simulation.

## Structure
- Shared package/include fpaddsub_pkg:
  - MANT_W and EXP_W.
  - SHIFT_SAT = 25, the saturation point of the shift.
- Sub-module fpaddsub_align_shifter:
  - Combinational.
  - Inputs: Msmall, diff. Outputs: Mal, Sticky.
  - Instantiated in stage 2.
- Handshake and pipeline registers live in the top module.

## Test plan
- A=1.0 (Ea=127, Ma=25'h1000000), B=0.5 (Eb=126, Mb=25'h1000000), out_ready=1
  -> out_valid exactly 2 cycles later; Emax=127, Mmax=25'h1000000, Mal=25'h0800000, Sticky=0, Swap=0, OpSub=0.
- A=0.5, B=−1.0; then equal exponents 130 with Ma=25'h1000002, Mb=25'h1000004
  -> first result: Swap=1, Sl=1, OpSub=1, Emax=127; second result: Swap=1, Mmax=25'h1000004, Mal=25'h1000002.
- Shift boundaries: Ea=130, Mb=25'h1000000, with Eb=106 (diff 24), 105 (diff 25), 80 (diff 50, Mb=25'h1000001)
  -> results in order: Mal=1/Sticky=0; Mal=0/Sticky=1; Mal=0/Sticky=1.
- Backpressure: stream 4 items back-to-back with out_ready=0 for cycles 0–5, then 1
  -> in_ready=0 once 2 items are held; the 4 items emerge in order with no loss or duplication.
- Full pipeline with in_valid=1 and out_ready=1 every cycle for 10 items
  -> 10 results on consecutive cycles after the 2-cycle fill.
- rst pulsed for one cycle with both stages full
  -> out_valid=0 and in_ready=1 on the next cycle; no stale item appears afterwards.
